// File: rtl/conv_weight_loader.sv
// conv_weight_loader
//   Programs one conv layer's weight store. On start it streams NUM_WORDS
//   16-bit words from a fixed-latency read-only weight memory onto the
//   layer's weight write port. When the last word has been written it pulses
//   done and raises layer_ready.
//
//   Optional feature, enabled by defining WEIGHT_LOADER_CHECKSUM_EN:
//     - adds the input expected_sum[15:0] and the output sum_err;
//     - keeps a 16-bit wraparound sum of the written words;
//     - on a checksum mismatch, sum_err is raised and layer_ready is withheld.
//
//   State sequence: IDLE -> ISSUE -> DRAIN -> IDLE.
//   The current state is visible on dbg_state.
//
//   Handshake semantics: this block has no backpressure on either side.
//     - mem_rd_en is a one-cycle read strobe.
//       Its data is captured exactly READ_LATENCY cycles later.
//     - weight_wr_en is a one-cycle write strobe.
//       weight_wr_addr and weight_wr_data are valid only while it is high.
//     - hold only gates the issue of new reads.
//       Reads already in flight always complete and are written.
module conv_weight_loader #(
  parameter int unsigned NUM_WORDS     = 78,
  parameter int unsigned SRC_BASE_ADDR = 0,
  parameter int unsigned DST_BASE_ADDR = 0,
  parameter int unsigned READ_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  output logic        mem_rd_en,
  output logic [31:0] mem_rd_addr,
  input  logic [15:0] mem_rd_data,
  output logic [15:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  output logic        busy,
  output logic        done,
  output logic        layer_ready,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  input  logic [15:0] expected_sum,
  output logic        sum_err,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);
  localparam logic [31:0] SRC_BASE = 32'(SRC_BASE_ADDR);
  localparam logic [31:0] DST_BASE = 32'(DST_BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]             r_issue_cnt;
  logic [31:0]             r_wr_cnt;
  logic [READ_LATENCY-1:0] r_vpipe;
  logic                    r_wr_en;
  logic [15:0]             r_wr_data;
  logic [31:0]             r_wr_addr;
  logic                    r_done;
  logic                    r_layer_ready;

  logic w_start_acc;
  logic w_rd_fire;
  logic w_tap;
  logic w_issue_last;
  logic w_wr_last;
  logic w_sum_ok;

  // A start request is honoured only from IDLE; otherwise it is silently dropped.
  assign w_start_acc  = (r_state == S_IDLE) && start;
  assign w_rd_fire    = (r_state == S_ISSUE) && !hold;
  assign w_tap        = r_vpipe[READ_LATENCY-1];
  assign w_issue_last = (r_issue_cnt == LAST_IDX);
  // The last write can only happen in DRAIN.
  // The final read always precedes its write by READ_LATENCY+1 cycles.
  assign w_wr_last    = (r_state == S_DRAIN) && w_tap && (r_wr_cnt == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_rd_fire && w_issue_last) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_wr_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state: read strobe/address, busy, debug state
  always_comb begin
    mem_rd_en   = w_rd_fire;
    mem_rd_addr = SRC_BASE + r_issue_cnt;
    busy        = (r_state != S_IDLE);
    dbg_state   = r_state;
  end

  // Read issue counter: cleared on accepted start, advances per issued read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt <= '0;
    end else if (w_start_acc) begin
      r_issue_cnt <= '0;
    end else if (w_rd_fire) begin
      r_issue_cnt <= r_issue_cnt + 32'd1;
    end
  end

  // Return-path valid pipe.
  // Its tap lines up with mem_rd_data of the matching read.
  generate
    if (READ_LATENCY == 1) begin : g_pipe_one
      // Single-stage valid pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe <= w_rd_fire;
        end
      end
    end else begin : g_pipe_multi
      // Multi-stage valid shift register
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe <= {r_vpipe[READ_LATENCY-2:0], w_rd_fire};
        end
      end
    end
  endgenerate

  // Write port register.
  // It captures returned data and stamps the destination address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_wr_cnt  <= '0;
    end else begin
      r_wr_en <= w_tap;
      if (w_start_acc) begin
        r_wr_cnt <= '0;
      end else if (w_tap) begin
        r_wr_data <= mem_rd_data;
        r_wr_addr <= DST_BASE + r_wr_cnt;
        r_wr_cnt  <= r_wr_cnt + 32'd1;
      end
    end
  end

  // Completion pulse and ready level.
  // A start arriving on the completing edge sees DRAIN and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done        <= 1'b0;
      r_layer_ready <= 1'b0;
    end else begin
      r_done <= w_wr_last;
      if (w_start_acc) begin
        r_layer_ready <= 1'b0;
      end else if (w_wr_last && w_sum_ok) begin
        r_layer_ready <= 1'b1;
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [15:0] r_exp_sum;
  logic        r_sum_err;
  logic [15:0] w_sum_next;

  // The final word is folded in combinationally.
  // This lets the verdict land on the completing edge.
  assign w_sum_next = r_sum + mem_rd_data;
  assign w_sum_ok   = (w_sum_next == r_exp_sum);
  assign sum_err    = r_sum_err;

  // Running checksum of written words.
  // expected_sum is captured on start; the error flag is held until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum     <= '0;
      r_exp_sum <= '0;
      r_sum_err <= 1'b0;
    end else if (w_start_acc) begin
      r_sum     <= '0;
      r_exp_sum <= expected_sum;
      r_sum_err <= 1'b0;
    end else if (w_tap) begin
      r_sum <= w_sum_next;
      if (w_wr_last) begin
        r_sum_err <= !w_sum_ok;
      end
    end
  end
`else
  assign w_sum_ok = 1'b1;
`endif

  assign weight_wr_en   = r_wr_en;
  assign weight_wr_data = r_wr_data;
  assign weight_wr_addr = r_wr_addr;
  assign done           = r_done;
  assign layer_ready    = r_layer_ready;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader.
// The main instance uses the default parameters.
// Two NUM_WORDS=1 instances exercise READ_LATENCY=1 and READ_LATENCY=8.
// Weight memory content: mem[a] = a + 0x100.
// The memory model returns 0xDEAD when it was not read.
module tb_conv_weight_loader;

  localparam int NW = 78;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main DUT ----------------
  logic        start, hold;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        weight_wr_en, busy, done, layer_ready;
  logic [1:0]  dbg_state;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] expected_sum;
  logic        sum_err;
  logic        sum_err1, sum_err8;
`endif

  conv_weight_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
    .weight_wr_en(weight_wr_en), .busy(busy), .done(done), .layer_ready(layer_ready),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    .expected_sum(expected_sum), .sum_err(sum_err),
`endif
    .dbg_state(dbg_state)
  );

  logic [15:0] mp0 [0:1];
  always @(posedge clk) begin
    mp0[0] <= mem_rd_en ? 16'(mem_rd_addr[15:0] + 16'h100) : 16'hDEAD;
    mp0[1] <= mp0[0];
  end
  assign mem_rd_data = mp0[1];

  // ---------------- RL=1 instance ----------------
  logic        start1, rd_en1, wr_en1, busy1, done1, ready1;
  logic [31:0] rd_addr1, wr_addr1;
  logic [15:0] rd_data1, wr_data1;
  logic [1:0]  dbg1;

  conv_weight_loader #(.NUM_WORDS(1), .SRC_BASE_ADDR(5), .DST_BASE_ADDR(32'h200),
                       .READ_LATENCY(1)) u_rl1 (
    .clk(clk), .rst(rst), .start(start1), .hold(1'b0),
    .mem_rd_en(rd_en1), .mem_rd_addr(rd_addr1), .mem_rd_data(rd_data1),
    .weight_wr_data(wr_data1), .weight_wr_addr(wr_addr1),
    .weight_wr_en(wr_en1), .busy(busy1), .done(done1), .layer_ready(ready1),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    .expected_sum(16'h0105), .sum_err(sum_err1),
`endif
    .dbg_state(dbg1)
  );

  logic [15:0] mp1;
  always @(posedge clk) mp1 <= rd_en1 ? 16'(rd_addr1[15:0] + 16'h100) : 16'hDEAD;
  assign rd_data1 = mp1;

  // ---------------- RL=8 instance ----------------
  logic        start8, rd_en8, wr_en8, busy8, done8, ready8;
  logic [31:0] rd_addr8, wr_addr8;
  logic [15:0] rd_data8, wr_data8;
  logic [1:0]  dbg8;

  conv_weight_loader #(.NUM_WORDS(1), .SRC_BASE_ADDR(32'h10), .DST_BASE_ADDR(32'h1000),
                       .READ_LATENCY(8)) u_rl8 (
    .clk(clk), .rst(rst), .start(start8), .hold(1'b0),
    .mem_rd_en(rd_en8), .mem_rd_addr(rd_addr8), .mem_rd_data(rd_data8),
    .weight_wr_data(wr_data8), .weight_wr_addr(wr_addr8),
    .weight_wr_en(wr_en8), .busy(busy8), .done(done8), .layer_ready(ready8),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    .expected_sum(16'h0110), .sum_err(sum_err8),
`endif
    .dbg_state(dbg8)
  );

  logic [15:0] mp8 [0:7];
  always @(posedge clk) begin
    mp8[0] <= rd_en8 ? 16'(rd_addr8[15:0] + 16'h100) : 16'hDEAD;
    for (int i = 1; i < 8; i++) mp8[i] <= mp8[i-1];
  end
  assign rd_data8 = mp8[7];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [47:0] exp_q[$];     // {addr, data} of expected writes
  logic [31:0] exp_rd_q[$];  // expected read addresses
  int rd_cyc_q[$];
  int wr_cyc_q[$];
  int done_cnt = 0;
  int done_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops expected reads/writes as the DUT produces them
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) begin
        rd_cyc_q.push_back(cyc);
        if (exp_rd_q.size() == 0) check("rd_unexpected", mem_rd_en, 1'b0);
        else check("rd_addr", mem_rd_addr, exp_rd_q.pop_front());
      end
      if (weight_wr_en) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("wr_unexpected", weight_wr_en, 1'b0);
        else check("wr_addr_data", {weight_wr_addr, weight_wr_data}, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy_low", busy, 1'b0);
        check("done_with_last_wr", weight_wr_en, 1'b1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_load(input logic [15:0] esum);
    rd_cyc_q.delete();
    wr_cyc_q.delete();
    done_cnt = 0;
    for (int i = 0; i < NW; i++) begin
      exp_rd_q.push_back(32'(i));
      exp_q.push_back({32'(i), 16'(i + 'h100)});
    end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    expected_sum = esum;
`else
    if (esum == 16'hFFFF) $display("note: unused checksum %0h", esum);
`endif
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_reads(input int n);
    int k = 0;
    while (rd_cyc_q.size() < n && k < 500) begin
      @(posedge clk);
      k++;
    end
    check("reads_reached", 32'(rd_cyc_q.size() >= n), 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", 32'(done_cnt), 1);
  endtask

  // Post-load audit; gap_idx is the read index expected to follow a 5-cycle hold
  task automatic check_load(input string tag, input int gap_idx, input int idle);
    int errs = 0;
    repeat (idle) @(negedge clk);
    check({tag, "_nreads"}, 32'(rd_cyc_q.size()), NW);
    check({tag, "_nwrites"}, 32'(wr_cyc_q.size()), NW);
    check({tag, "_ndone"}, 32'(done_cnt), 1);
    check({tag, "_sb_empty"}, 32'(exp_q.size() + exp_rd_q.size()), 0);
    check({tag, "_ready"}, layer_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    if (rd_cyc_q.size() == NW && wr_cyc_q.size() == NW) begin
      for (int i = 1; i < NW; i++) begin
        int ed = (i == gap_idx) ? 6 : 1;
        if (rd_cyc_q[i] - rd_cyc_q[i-1] != ed) errs++;
        if (wr_cyc_q[i] - wr_cyc_q[i-1] != ed) errs++;
      end
      check({tag, "_spacing_errs"}, 32'(errs), 0);
      check({tag, "_first_wr_lat"}, 32'(wr_cyc_q[0] - rd_cyc_q[0]), 3);
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'(wr_cyc_q[NW-1]));
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] good_sum;
  int lat;

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; start1 = 1'b0; start8 = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    expected_sum = '0;
`endif
    good_sum = '0;
    for (int i = 0; i < NW; i++) good_sum = good_sum + 16'(i + 'h100);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_rd_addr", mem_rd_addr, 32'h0);
    check("rst_wr_en", weight_wr_en, 1'b0);
    check("rst_wr_addr_data", {weight_wr_addr, weight_wr_data}, 48'h0);
    check("rst_flags", {busy, done, layer_ready}, 3'b000);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: plain load
    start_load(good_sum);
    @(negedge clk);
    check("ld1_busy", busy, 1'b1);
    check("ld1_state", dbg_state, 2'd1);
    wait_done();
    check_load("ld1", -1, 5);

    // 2: hold for 5 cycles after 10th read; reload while ready=1
    start_load(good_sum);
    @(negedge clk);
    check("ld2_ready_dropped", layer_ready, 1'b0);
    wait_reads(10);
    #1 hold = 1'b1;
    repeat (5) @(posedge clk);
    #1 hold = 1'b0;
    wait_done();
    check_load("ld2_hold", 10, 5);

    // 3: start at word 40 and on the completing edge are ignored
    start_load(good_sum);
    wait_reads(40);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_reads(NW);
    #1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    check_load("ld3_ignore", -1, 20);

    // 4: reset mid-load at word 30, then a clean reload
    start_load(good_sum);
    wait_reads(30);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exp_rd_q.delete();
    @(negedge clk);
    check("rst_mid_wr_en", weight_wr_en, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ready", layer_ready, 1'b0);
    repeat (15) @(negedge clk);
    check("rst_mid_quiet", {weight_wr_en, mem_rd_en, busy}, 3'b000);
    start_load(good_sum);
    wait_done();
    check_load("ld4_after_rst", -1, 5);

    // 5: READ_LATENCY=1, NUM_WORDS=1
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    check("rl1_rd", {rd_en1, rd_addr1}, {1'b1, 32'h5});
    lat = 0;
    while (!wr_en1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rl1_latency", 32'(lat), 2);
    check("rl1_wr", {wr_addr1, wr_data1}, {32'h200, 16'h0105});
    check("rl1_flags", {done1, busy1, ready1}, 3'b101);
    @(negedge clk);
    check("rl1_after", {wr_en1, done1, ready1}, 3'b001);

    // 6: READ_LATENCY=8, NUM_WORDS=1
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    @(negedge clk);
    check("rl8_rd", {rd_en8, rd_addr8}, {1'b1, 32'h10});
    lat = 0;
    while (!wr_en8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rl8_latency", 32'(lat), 9);
    check("rl8_wr", {wr_addr8, wr_data8}, {32'h1000, 16'h0110});
    check("rl8_flags", {done8, busy8, ready8}, 3'b101);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // 7: checksum correct, then off by one
    start_load(good_sum);
    wait_done();
    repeat (3) @(negedge clk);
    check("cks_ok", {sum_err, layer_ready}, 2'b01);
    start_load(good_sum + 16'd1);
    wait_done();
    repeat (3) @(negedge clk);
    check("cks_bad", {sum_err, layer_ready}, 2'b10);
    check("cks_bad_done", 32'(done_cnt), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
